// File: rtl/bcd_display_mux_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bcd_display_mux_pkg
// Purpose  : Shared constants for the 2-digit seven-segment display driver:
//            active-low segment patterns ({g,f,e,d,c,b,a}), active-low anode
//            enables and the scan-slot type.
// Ports    : (package, none)
// Revision : 1.0 - initial release
// ============================================================================
package bcd_display_mux_pkg;

  // Segment patterns, active-low, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_DASH  = 7'h3F;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Digit enables, active-low: an[0]=units, an[1]=tens
  localparam logic [1:0] AN_UNITS = 2'b10;
  localparam logic [1:0] AN_TENS  = 2'b01;
  localparam logic [1:0] AN_OFF   = 2'b11;

  // Which digit the scan is currently lighting
  typedef enum logic {
    SLOT_UNITS = 1'b0,
    SLOT_TENS  = 1'b1
  } slot_e;

endpackage : bcd_display_mux_pkg
`default_nettype wire

// File: rtl/bcd_display_mux_bcd_to_seg7.sv
`default_nettype none
// ============================================================================
// Module   : bcd_to_seg7
// Purpose  : Combinational 4-bit code to active-low seven-segment pattern.
//            Codes 10-15 produce a dash.
// Ports    : code [3:0] in  - digit code
//            seg  [6:0] out - {g,f,e,d,c,b,a}, active-low
// Revision : 1.0 - initial release
// ============================================================================
module bcd_to_seg7
  import bcd_display_mux_pkg::*;
(
  input  logic [3:0] code,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_DASH;
    case (code)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule : bcd_to_seg7
`default_nettype wire

// File: rtl/bcd_display_mux.sv
`default_nettype none
// ============================================================================
// Module   : bcd_display_mux
// Purpose  : Drives a 2-digit multiplexed common-anode seven-segment display
//            from the timer's BCD digits. Frame-synchronous capture (no
//            tearing), leading-zero blanking, dash for invalid codes, blink
//            of "00" and a one-cycle expiry pulse.
// Ports    : clk        in   system clock, rising edge
//            reset      in   asynchronous active-low reset
//            q0  [3:0]  in   units digit
//            q1  [2:0]  in   tens digit
//            blink_en   in   blink while the latched value is 00
//            seg [6:0]  out  segments {g,f,e,d,c,b,a}, active-low, registered
//            an  [1:0]  out  digit enables, active-low, registered
//            expired    out  one-cycle pulse when latched value becomes 00
// Revision : 1.0 - initial release
// ============================================================================
module bcd_display_mux
  import bcd_display_mux_pkg::*;
#(
  parameter int REFRESH_DIV = 50000,
  parameter int BLINK_DIV   = 25000000,
  parameter int BLANK_LZ    = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] q0,
  input  logic [2:0] q1,
  input  logic       blink_en,
  output logic [6:0] seg,
  output logic [1:0] an,
  output logic       expired
);

  localparam int RCW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int BCW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [RCW-1:0] REFRESH_LAST = RCW'(REFRESH_DIV - 1);
  localparam logic [BCW-1:0] BLINK_LAST   = BCW'(BLINK_DIV - 1);

  logic [RCW-1:0] refresh_cnt;
  slot_e          sel;
  logic [3:0]     units_sh;
  logic [2:0]     tens_sh;
  logic [BCW-1:0] blink_cnt;
  logic           blink_vis;

  logic           refresh_wrap;
  logic           frame_end;
  logic           shadow_zero;
  logic           blink_active;
  logic           expire_now;
  logic [3:0]     dec_code;
  logic [6:0]     dec_seg;
  logic [6:0]     seg_next;
  logic [1:0]     an_next;

  assign refresh_wrap = (refresh_cnt == REFRESH_LAST);
  // Capture only at the end of the tens slot so a whole frame shows one value
  assign frame_end    = refresh_wrap && (sel == SLOT_TENS);
  assign shadow_zero  = (units_sh == 4'd0) && (tens_sh == 3'd0);
  assign blink_active = blink_en && shadow_zero;
  assign expire_now   = frame_end && !shadow_zero && (q0 == 4'd0) && (q1 == 3'd0);

  // Tens code 7 is out of range for a seconds timer; remap it to a dash code
  always_comb begin
    dec_code = units_sh;
    if (sel == SLOT_TENS) begin
      dec_code = (tens_sh == 3'd7) ? 4'hF : {1'b0, tens_sh};
    end
  end

  bcd_to_seg7 u_dec (
    .code (dec_code),
    .seg  (dec_seg)
  );

  // blink_en is used directly so dropping it un-blanks on the very next edge
  always_comb begin
    seg_next = dec_seg;
    an_next  = (sel == SLOT_TENS) ? AN_TENS : AN_UNITS;
    if (blink_active && !blink_vis) begin
      seg_next = SEG_BLANK;
      an_next  = AN_OFF;
    end else if ((sel == SLOT_TENS) && (BLANK_LZ != 0) && (tens_sh == 3'd0)) begin
      seg_next = SEG_BLANK;
      an_next  = AN_OFF;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      refresh_cnt <= '0;
      sel         <= SLOT_UNITS;
      units_sh    <= 4'd0;
      tens_sh     <= 3'd0;
      blink_cnt   <= '0;
      blink_vis   <= 1'b1;
      seg         <= SEG_BLANK;
      an          <= AN_OFF;
      expired     <= 1'b0;
    end else begin
      if (refresh_wrap) begin
        refresh_cnt <= '0;
        sel         <= (sel == SLOT_UNITS) ? SLOT_TENS : SLOT_UNITS;
      end else begin
        refresh_cnt <= refresh_cnt + 1'b1;
      end

      if (frame_end) begin
        units_sh <= q0;
        tens_sh  <= q1;
      end

      if (blink_active) begin
        if (blink_cnt == BLINK_LAST) begin
          blink_cnt <= '0;
          blink_vis <= ~blink_vis;
        end else begin
          blink_cnt <= blink_cnt + 1'b1;
        end
      end else begin
        blink_cnt <= '0;
        blink_vis <= 1'b1;
      end

      seg     <= seg_next;
      an      <= an_next;
      expired <= expire_now;
    end
  end

endmodule : bcd_display_mux
`default_nettype wire

// File: tb/tb_bcd_display_mux.sv
`default_nettype none
// ============================================================================
// Module   : tb_bcd_display_mux
// Purpose  : Self-checking bench for bcd_display_mux (REFRESH_DIV=4,
//            BLINK_DIV=16, BLANK_LZ=1). A cycle-level reference model derived
//            from elapsed-cycle arithmetic is compared every cycle; directed
//            literal checks pin the model, followed by randomized stimulus.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_bcd_display_mux;

  localparam int R = 4;
  localparam int B = 16;

  logic       clk;
  logic       reset;
  logic [3:0] q0;
  logic [2:0] q1;
  logic       blink_en;
  logic [6:0] seg;
  logic [1:0] an;
  logic       expired;

  int checks = 0;
  int errors = 0;
  int pulses = 0;

  bcd_display_mux #(
    .REFRESH_DIV (R),
    .BLINK_DIV   (B),
    .BLANK_LZ    (1)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .q0       (q0),
    .q1       (q1),
    .blink_en (blink_en),
    .seg      (seg),
    .an       (an),
    .expired  (expired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: digit glyph table
  logic [6:0] seg_tab [0:9] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  // Model state: cycles since reset (mod one frame), latched digits,
  // consecutive cycles the blink condition has held.
  int         m_t = 0;
  int         m_n = 0;
  logic [3:0] m_u = 4'd0;
  logic [2:0] m_ts = 3'd0;

  initial begin : compare_proc
    logic [6:0] e_seg;
    logic [1:0] e_an;
    logic       e_exp;
    bit         cap, z, vis;
    int         slot;
    forever begin
      @(posedge clk);
      if (!reset) begin
        e_seg = 7'h7F; e_an = 2'b11; e_exp = 1'b0;
        m_t = 0; m_n = 0; m_u = 4'd0; m_ts = 3'd0;
      end else begin
        slot = (m_t / R) % 2;
        vis  = ((m_n / B) % 2) == 0;
        z    = (m_u == 4'd0) && (m_ts == 3'd0);
        if (blink_en && z && !vis) begin
          e_seg = 7'h7F; e_an = 2'b11;
        end else if (slot == 0) begin
          e_an = 2'b10;
          e_seg = (m_u > 4'd9) ? 7'h3F : seg_tab[m_u];
        end else if (m_ts == 3'd0) begin
          e_seg = 7'h7F; e_an = 2'b11;
        end else begin
          e_an = 2'b01;
          e_seg = (m_ts == 3'd7) ? 7'h3F : seg_tab[m_ts];
        end
        cap   = (m_t % (2 * R)) == (2 * R - 1);
        e_exp = cap && !z && (q0 == 4'd0) && (q1 == 3'd0);
        if (cap) begin
          m_u = q0; m_ts = q1;
        end
        m_n = (blink_en && z) ? ((m_n + 1) % (2 * B)) : 0;
        m_t = (m_t + 1) % (2 * R);
      end
      #1;
      checks++;
      if ({seg, an, expired} !== {e_seg, e_an, e_exp}) begin
        errors++;
        $display("FAIL model_cycle t=%0t got seg=%h an=%b exp=%b want seg=%h an=%b exp=%b",
                 $time, seg, an, expired, e_seg, e_an, e_exp);
      end
      if (expired === 1'b1) pulses++;
    end
  end

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h want %h", name, got, want);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_an(input string name, input logic [1:0] target);
    bit found;
    found = 0;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      if (an === target) begin
        found = 1;
        break;
      end
    end
    if (!found) begin
      checks++;
      errors++;
      $display("FAIL %s timeout waiting an=%b got an=%b", name, target, an);
    end
  endtask

  initial begin : timeout_guard
    #400000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int p0, blanks, run;
    bit found;
    reset = 1'b0; q0 = 4'd0; q1 = 3'd0; blink_en = 1'b0;
    tick(3);
    chk("reset_state", {7'h0, seg, an}, {7'h0, 7'h7F, 2'b11});
    chk("reset_expired", {15'h0, expired}, 16'h0);

    // Release with 59 loaded
    q1 = 3'd5; q0 = 4'd9;
    reset = 1'b1;
    tick(16);
    wait_an("units59", 2'b10);
    chk("units59_seg", {9'h0, seg}, 16'h10);
    wait_an("tens59", 2'b01);
    chk("tens59_seg", {9'h0, seg}, 16'h12);

    // Tearing: change units mid-slot
    q0 = 4'd3;
    tick(16);
    wait_an("tear_tens", 2'b01);
    wait_an("tear_units", 2'b10);
    tick(1);
    q0 = 4'd7;
    tick(1);
    chk("tear_hold_seg", {7'h0, seg, an}, {7'h0, 7'h30, 2'b10});
    found = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (an == 2'b10 && seg == 7'h78) begin
        found = 1;
        break;
      end
    end
    chk("tear_new_units", {15'h0, found}, 16'h1);

    // Leading zero
    q1 = 3'd0; q0 = 4'd4;
    tick(16);
    wait_an("lz_units", 2'b10);
    chk("lz_units_seg", {9'h0, seg}, 16'h19);
    wait_an("lz_tens", 2'b11);
    chk("lz_tens_seg", {9'h0, seg}, 16'h7F);

    // Invalid codes
    q1 = 3'd5; q0 = 4'd12;
    tick(16);
    wait_an("inv_units", 2'b10);
    chk("inv_units_seg", {9'h0, seg}, 16'h3F);
    q1 = 3'd7; q0 = 4'd1;
    tick(16);
    wait_an("inv_tens", 2'b01);
    chk("inv_tens_seg", {9'h0, seg}, 16'h3F);

    // Expiry
    q1 = 3'd0; q0 = 4'd1;
    tick(16);
    p0 = pulses;
    q0 = 4'd0;
    tick(16);
    chk("expire_once", 16'(pulses - p0), 16'd1);
    tick(100);
    chk("expire_hold", 16'(pulses - p0), 16'd1);
    q1 = 3'd6; q0 = 4'd0; tick(16);
    q1 = 3'd1; q0 = 4'd0; tick(16);
    q1 = 3'd0; q0 = 4'd1; tick(16);
    q0 = 4'd0;            tick(16);
    chk("expire_rearm", 16'(pulses - p0), 16'd2);

    // Blink with 00 latched: 32 off cycles plus 16 tens-blank cycles per 64
    blink_en = 1'b1;
    blanks = 0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (an == 2'b11 && seg == 7'h7F) blanks++;
    end
    chk("blink_blank_count", 16'(blanks), 16'd48);
    run = 0;
    for (int i = 0; i < 40 && run < 9; i++) begin
      @(negedge clk);
      run = (an == 2'b11) ? run + 1 : 0;
    end
    chk("blink_off_found", 16'(run >= 9), 16'd1);
    blink_en = 1'b0;
    found = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (an == 2'b10) begin
        found = 1;
        break;
      end
    end
    chk("blink_drop_visible", {15'h0, found}, 16'h1);

    // Asynchronous reset between edges while blinking
    blink_en = 1'b1;
    tick(20);
    wait_an("areset_vis", 2'b10);
    #1 reset = 1'b0;
    #1;
    chk("async_reset_out", {7'h0, seg, an}, {7'h0, 7'h7F, 2'b11});
    chk("async_reset_exp", {15'h0, expired}, 16'h0);
    tick(2);
    reset = 1'b1;
    blink_en = 1'b0;

    // Randomized stimulus
    for (int k = 0; k < 60; k++) begin
      if ($urandom_range(0, 9) < 3) begin
        q0 = 4'd0; q1 = 3'd0;
      end else begin
        q0 = 4'($urandom_range(0, 15));
        q1 = 3'($urandom_range(0, 7));
      end
      blink_en = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 19) == 0) begin
        reset = 1'b0;
        tick(2);
        reset = 1'b1;
      end
      tick($urandom_range(1, 40));
    end

    tick(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_bcd_display_mux
`default_nettype wire
